mediana_ctrl: RTL

Frame-level sequencer for the 3x3 median filter datapath. Raster-scans a WIDTH x HEIGHT 8-bit image held in a synchronous-read frame RAM and gathers each 3x3 neighbourhood with edge-replicate clamping. It computes the true median of the 9 pixels and writes each result to an output RAM through a valid/ready write port. It sits between the frame buffers and the host control logic, replacing the fully combinational whole-frame filter with a single time-shared median unit.

---
 rtl/mediana_pkg.sv | 28 ++
 rtl/median9.sv | 34 +++
 rtl/mediana_ctrl.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/mediana_pkg.sv
// mediana_pkg: shared definitions for the 3x3 median frame sequencer.
//   state_e        controller FSM states
//   NTAPS          taps per neighbourhood (3x3)
//   TAP_DR/TAP_DC  row/column offset of tap k, row-major from top-left
//   clamp_idx      edge-replicate clamp of a coordinate into [0, hi]
package mediana_pkg;

  localparam int unsigned NTAPS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT,
    ST_COMPUTE,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam int TAP_DR [NTAPS] = '{-1, -1, -1, 0, 0, 0, 1, 1, 1};
  localparam int TAP_DC [NTAPS] = '{-1, 0, 1, -1, 0, 1, -1, 0, 1};

  function automatic int clamp_idx(input int v, input int hi);
    if (v < 0) return 0;
    if (v > hi) return hi;
    return v;
  endfunction

endpackage

// File: rtl/median9.sv
// median9: combinational median of nine unsigned pixels (5th smallest,
// duplicates counted) using a 19-stage compare-exchange network.
//   pix_i  nine pixels packed, tap k at bits [k*PIX_W +: PIX_W]
//   med_o  median value
module median9
  import mediana_pkg::*;
#(
  parameter int PIX_W = 8
) (
  input  logic [NTAPS*PIX_W-1:0] pix_i,
  output logic [PIX_W-1:0]       med_o
);

  localparam int unsigned NCE = 19;
  // Pruned network: only exchanges that can influence the middle element.
  localparam int unsigned CE_A [NCE] = '{1, 4, 7, 0, 3, 6, 1, 4, 7, 0, 5, 4, 3, 1, 2, 4, 4, 6, 4};
  localparam int unsigned CE_B [NCE] = '{2, 5, 8, 1, 4, 7, 2, 5, 8, 3, 8, 7, 6, 4, 5, 7, 2, 4, 2};

  always_comb begin : sort
    logic [PIX_W-1:0] p [NTAPS];
    logic [PIX_W-1:0] t;
    t = '0;
    for (int unsigned i = 0; i < NTAPS; i++) p[i] = pix_i[i*PIX_W +: PIX_W];
    for (int unsigned s = 0; s < NCE; s++) begin
      if (p[CE_A[s]] > p[CE_B[s]]) begin
        t          = p[CE_A[s]];
        p[CE_A[s]] = p[CE_B[s]];
        p[CE_B[s]] = t;
      end
    end
    med_o = p[4];
  end

endmodule

// File: rtl/mediana_ctrl.sv
// mediana_ctrl: raster-scan sequencer feeding one shared median9 unit.
// For each pixel it reads the 3x3 edge-clamped neighbourhood from a
// synchronous-read frame RAM (one tap per cycle), registers the median and
// writes it out through a valid/ready port.
//   clk, rst_n           clock, async active-low reset
//   start, abort         frame start (IDLE only) / cancel
//   busy, done           frame in progress / one-cycle completion pulse
//   rd_en/rd_addr/rd_data  frame RAM read port (data one cycle after rd_en)
//   wr_en/wr_addr/wr_data/wr_ready  result write port
module mediana_ctrl
  import mediana_pkg::*;
#(
  parameter int WIDTH  = 100,
  parameter int HEIGHT = 100,
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 14
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [PIX_W-1:0]  rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [PIX_W-1:0]  wr_data,
  input  logic              wr_ready
);

  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int K_W   = $clog2(NTAPS);

  state_e             state_q, state_d;
  logic [ROW_W-1:0]   r_q, r_d;
  logic [COL_W-1:0]   c_q, c_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [PIX_W-1:0]   win_q [NTAPS];
  logic [PIX_W-1:0]   win_d [NTAPS];
  logic [PIX_W-1:0]   wr_data_q, wr_data_d;
  logic [NTAPS*PIX_W-1:0] win_flat;
  logic [PIX_W-1:0]   med;
  logic               last_col, last_pix, kill;
  int                 rr, cc;

  assign last_col = (c_q == COL_W'(WIDTH - 1));
  assign last_pix = last_col && (r_q == ROW_W'(HEIGHT - 1));
  assign kill     = abort && (state_q != ST_IDLE);

  always_comb begin
    win_flat = '0;
    for (int unsigned i = 0; i < NTAPS; i++) win_flat[i*PIX_W +: PIX_W] = win_q[i];
  end

  median9 #(.PIX_W(PIX_W)) u_median9 (
    .pix_i (win_flat),
    .med_o (med)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_FETCH;
      ST_FETCH:   if (k_q == K_W'(NTAPS - 1)) state_d = ST_WAIT;
      ST_WAIT:    state_d = ST_COMPUTE;
      ST_COMPUTE: state_d = ST_WRITE;
      ST_WRITE:   if (wr_ready) state_d = last_pix ? ST_DONE : ST_FETCH;
      ST_DONE:    state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
    if (kill) state_d = ST_IDLE;
  end

  // Output logic
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    rd_en   = 1'b0;
    wr_en   = 1'b0;
    rd_addr = '0;
    rr      = clamp_idx(int'(r_q) + TAP_DR[k_q], HEIGHT - 1);
    cc      = clamp_idx(int'(c_q) + TAP_DC[k_q], WIDTH - 1);
    case (state_q)
      ST_FETCH: begin
        busy    = 1'b1;
        rd_en   = 1'b1;
        rd_addr = ADDR_W'(rr * WIDTH + cc);
      end
      ST_WAIT, ST_COMPUTE: busy = 1'b1;
      ST_WRITE: begin
        busy  = 1'b1;
        wr_en = 1'b1;
      end
      ST_DONE: done = 1'b1;
      default: ;
    endcase
  end

  assign wr_addr = ADDR_W'(int'(r_q) * WIDTH + int'(c_q));
  assign wr_data = wr_data_q;

  // Datapath next state: tap k's read data lands while k+1 is being issued,
  // so the window slot written lags the tap counter by one.
  always_comb begin
    r_d       = r_q;
    c_d       = c_q;
    k_d       = k_q;
    wr_data_d = wr_data_q;
    for (int unsigned i = 0; i < NTAPS; i++) win_d[i] = win_q[i];
    case (state_q)
      ST_IDLE: if (start) begin
        r_d = '0;
        c_d = '0;
        k_d = '0;
      end
      ST_FETCH: begin
        if (k_q != '0) win_d[k_q - K_W'(1)] = rd_data;
        k_d = (k_q == K_W'(NTAPS - 1)) ? '0 : k_q + K_W'(1);
      end
      ST_WAIT:    win_d[NTAPS-1] = rd_data;
      ST_COMPUTE: wr_data_d = med;
      ST_WRITE: if (wr_ready) begin
        if (last_pix) begin
          r_d = '0;
          c_d = '0;
        end else if (last_col) begin
          c_d = '0;
          r_d = r_q + ROW_W'(1);
        end else begin
          c_d = c_q + COL_W'(1);
        end
      end
      default: ;
    endcase
    if (kill) begin
      r_d = '0;
      c_d = '0;
      k_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= '0;
      c_q       <= '0;
      k_q       <= '0;
      wr_data_q <= '0;
      for (int unsigned i = 0; i < NTAPS; i++) win_q[i] <= '0;
    end else begin
      r_q       <= r_d;
      c_q       <= c_d;
      k_q       <= k_d;
      wr_data_q <= wr_data_d;
      for (int unsigned i = 0; i < NTAPS; i++) win_q[i] <= win_d[i];
    end
  end

endmodule
